// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, colour widths and the timing-bundle type
// used by the VGA raster path.
package vga_pkg;

    localparam int DEF_HACTIVE = 640;
    localparam int DEF_HFP     = 16;
    localparam int DEF_HSYNC   = 96;
    localparam int DEF_HBP     = 48;

    localparam int DEF_VACTIVE = 480;
    localparam int DEF_VFP     = 10;
    localparam int DEF_VSYNC   = 2;
    localparam int DEF_VBP     = 33;

    localparam logic DEF_HPOL = 1'b0;
    localparam logic DEF_VPOL = 1'b0;

    localparam int DEF_RW = 3;
    localparam int DEF_GW = 3;
    localparam int DEF_BW = 2;

    localparam int DEF_PIX_LAT = 1;
    localparam int DEF_FCW     = 8;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } timing_t;

endpackage

// File: rtl/vga_timing_core_if.sv
// Bundle between the raster core and its pixel generator / video sink:
// coordinates and strobes out, colour in, aligned video out.
interface vga_timing_core_if #(
    parameter int RW  = 3,
    parameter int GW  = 3,
    parameter int BW  = 2,
    parameter int FCW = 8
) ();
    logic [9:0]     hcount;
    logic [9:0]     vcount;
    logic           frame_start;
    logic           line_start;
    logic [FCW-1:0] frame_cnt;
    logic [RW-1:0]  rin;
    logic [GW-1:0]  gin;
    logic [BW-1:0]  bin;
    logic [RW-1:0]  rout;
    logic [GW-1:0]  gout;
    logic [BW-1:0]  bout;
    logic           hsync;
    logic           vsync;
    logic           de;

    modport master (
        output hcount, vcount, frame_start, line_start, frame_cnt,
        output rout, gout, bout, hsync, vsync, de,
        input  rin, gin, bin
    );

    modport slave (
        input  hcount, vcount, frame_start, line_start, frame_cnt,
        input  rout, gout, bout, hsync, vsync, de,
        output rin, gin, bin
    );
endinterface

// File: rtl/vga_delay_line.sv
// ce-gated shift register of parametrised width/depth with synchronous reset
// to a configurable idle value; depth 0 is a plain wire.
module vga_delay_line #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_ce};
            assign o_q      = i_d;
        end else begin : g_dly
            logic [W-1:0] r_sr [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
                end else if (i_ce) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_core.sv
// Raster timing generator plus pixel-alignment stage, advanced by a pixel clock-enable.
// Optional VGA_TESTPATTERN_EN replaces the rin/gin/bin colour with 8 vertical colour bars.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int   HACTIVE = DEF_HACTIVE,
    parameter int   HFP     = DEF_HFP,
    parameter int   HSYNC   = DEF_HSYNC,
    parameter int   HBP     = DEF_HBP,
    parameter int   VACTIVE = DEF_VACTIVE,
    parameter int   VFP     = DEF_VFP,
    parameter int   VSYNC   = DEF_VSYNC,
    parameter int   VBP     = DEF_VBP,
    parameter logic HPOL    = DEF_HPOL,
    parameter logic VPOL    = DEF_VPOL,
    parameter int   RW      = DEF_RW,
    parameter int   GW      = DEF_GW,
    parameter int   BW      = DEF_BW,
    parameter int   PIX_LAT = DEF_PIX_LAT,
    parameter int   FCW     = DEF_FCW
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ce,
    vga_timing_core_if.master  io_vga
);
    localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
    localparam int CW     = RW + GW + BW;

    localparam logic [9:0] H_LAST = 10'(HTOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(VTOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(HACTIVE);
    localparam logic [9:0] V_ACT  = 10'(VACTIVE);
    localparam logic [9:0] HS_LO  = 10'(HACTIVE + HFP);
    localparam logic [9:0] HS_HI  = 10'(HACTIVE + HFP + HSYNC);
    localparam logic [9:0] VS_LO  = 10'(VACTIVE + VFP);
    localparam logic [9:0] VS_HI  = 10'(VACTIVE + VFP + VSYNC);

    localparam timing_t TIM_IDLE = '{active: 1'b0, hs: ~HPOL, vs: ~VPOL};

    logic [9:0]     r_hcount;
    logic [9:0]     r_vcount;
    logic [FCW-1:0] r_frame_cnt;
    logic [RW-1:0]  r_rout;
    logic [GW-1:0]  r_gout;
    logic [BW-1:0]  r_bout;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;

    logic           w_line_start;
    logic           w_frame_start;
    timing_t        w_tim_now;
    timing_t        w_tim_dly;
    logic [RW-1:0]  w_src_r;
    logic [GW-1:0]  w_src_g;
    logic [BW-1:0]  w_src_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (i_ce) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    // Strobes belong to the coordinate stage and are gated so reset never shows a stale origin.
    assign w_line_start  = i_ce && !i_rst && (r_hcount == 10'd0);
    assign w_frame_start = w_line_start && (r_vcount == 10'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_tim_now.active = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign w_tim_now.hs     = (r_hcount >= HS_LO && r_hcount < HS_HI) ? HPOL : ~HPOL;
    assign w_tim_now.vs     = (r_vcount >= VS_LO && r_vcount < VS_HI) ? VPOL : ~VPOL;

`ifdef VGA_TESTPATTERN_EN
    localparam int          DW       = $bits(timing_t) + CW;
    localparam logic [DW-1:0] DLY_IDLE = {{CW{1'b0}}, TIM_IDLE};
    localparam logic [9:0]  BAR_W    = 10'(HACTIVE / 8);

    logic [DW-1:0] w_dly_in;
    logic [DW-1:0] w_dly_out;
    logic [2:0]    w_bar;
    logic [RW-1:0] w_pat_r;
    logic [GW-1:0] w_pat_g;
    logic [BW-1:0] w_pat_b;
    logic [CW-1:0] w_pat_dly;
    logic          w_unused;

    assign w_bar = 3'(r_hcount / BAR_W);

    // Bar index bits land on the channel MSBs only; the pattern rides the delay line with the syncs.
    always_comb begin
        w_pat_r = '0;
        w_pat_g = '0;
        w_pat_b = '0;
        w_pat_r[RW-1] = w_bar[2];
        w_pat_g[GW-1] = w_bar[1];
        w_pat_b[BW-1] = w_bar[0];
    end

    assign w_dly_in               = {w_pat_r, w_pat_g, w_pat_b, w_tim_now};
    assign {w_pat_dly, w_tim_dly} = w_dly_out;
    assign w_src_r                = w_pat_dly[CW-1 -: RW];
    assign w_src_g                = w_pat_dly[BW +: GW];
    assign w_src_b                = w_pat_dly[BW-1:0];
    assign w_unused               = ^{io_vga.rin, io_vga.gin, io_vga.bin};
`else
    localparam int            DW       = $bits(timing_t);
    localparam logic [DW-1:0] DLY_IDLE = TIM_IDLE;

    logic [DW-1:0] w_dly_in;
    logic [DW-1:0] w_dly_out;

    assign w_dly_in  = w_tim_now;
    assign w_tim_dly = w_dly_out;
    assign w_src_r   = io_vga.rin;
    assign w_src_g   = io_vga.gin;
    assign w_src_b   = io_vga.bin;
`endif

    vga_delay_line #(
        .W       (DW),
        .DEPTH   (PIX_LAT),
        .RST_VAL (DLY_IDLE)
    ) u_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_ce  (i_ce),
        .i_d   (w_dly_in),
        .o_q   (w_dly_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rout  <= '0;
            r_gout  <= '0;
            r_bout  <= '0;
            r_de    <= 1'b0;
            r_hsync <= ~HPOL;
            r_vsync <= ~VPOL;
        end else if (i_ce) begin
            r_rout  <= w_tim_dly.active ? w_src_r : '0;
            r_gout  <= w_tim_dly.active ? w_src_g : '0;
            r_bout  <= w_tim_dly.active ? w_src_b : '0;
            r_de    <= w_tim_dly.active;
            r_hsync <= w_tim_dly.hs;
            r_vsync <= w_tim_dly.vs;
        end
    end

    assign io_vga.hcount      = r_hcount;
    assign io_vga.vcount      = r_vcount;
    assign io_vga.frame_start = w_frame_start;
    assign io_vga.line_start  = w_line_start;
    assign io_vga.frame_cnt   = r_frame_cnt;
    assign io_vga.rout        = r_rout;
    assign io_vga.gout        = r_gout;
    assign io_vga.bout        = r_bout;
    assign io_vga.hsync       = r_hsync;
    assign io_vga.vsync       = r_vsync;
    assign io_vga.de          = r_de;
endmodule

// File: tb/tb_vga_timing_core.sv
// Randomised bench for vga_timing_core on a shrunken raster; expected values come
// from the ce-cycle index since reset. Honours VGA_TESTPATTERN_EN when defined.
module tb_vga_timing_core;
    localparam int   HA   = 16;
    localparam int   HF   = 2;
    localparam int   HS   = 3;
    localparam int   HB   = 3;
    localparam int   VA   = 8;
    localparam int   VF   = 1;
    localparam int   VS   = 2;
    localparam int   VB   = 2;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;
    localparam int   RW   = 3;
    localparam int   GW   = 3;
    localparam int   BW   = 2;
    localparam int   LAT  = 3;
    localparam int   FCW  = 4;

    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    int checks = 0;
    int passes = 0;
    int s      = 0;
    int lastR  = 0;
    int lastG  = 0;
    int lastB  = 0;

    vga_timing_core_if #(.RW(RW), .GW(GW), .BW(BW), .FCW(FCW)) vif ();

    vga_timing_core #(
        .HACTIVE (HA), .HFP (HF), .HSYNC (HS), .HBP (HB),
        .VACTIVE (VA), .VFP (VF), .VSYNC (VS), .VBP (VB),
        .HPOL (HPOL), .VPOL (VPOL),
        .RW (RW), .GW (GW), .BW (BW),
        .PIX_LAT (LAT), .FCW (FCW)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_ce   (ce),
        .io_vga (vif.master)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d (stage %0d, t=%0t)", tag, obs, exp, s, $time);
    endtask

    task automatic applyStimulus(input bit ceV, input bit rstV);
        ce      = ceV;
        rst     = rstV;
        vif.rin = RW'($urandom);
        vif.gin = GW'($urandom);
        vif.bin = BW'($urandom);
    endtask

    // Everything the DUT shows during stage s follows from s alone plus the last sampled colour.
    task automatic checkAll();
        int  t;
        int  x;
        int  y;
        int  k;
        bit  act;
        int  hsE;
        int  vsE;
        int  rE;
        int  gE;
        int  bE;
        t   = s - LAT - 1;
        act = 1'b0;
        hsE = int'(!HPOL);
        vsE = int'(!VPOL);
        rE  = 0;
        gE  = 0;
        bE  = 0;
        if (t >= 0) begin
            x   = t % HT;
            y   = (t / HT) % VT;
            act = (x < HA) && (y < VA);
            if (x >= HA + HF && x < HA + HF + HS) hsE = int'(HPOL);
            if (y >= VA + VF && y < VA + VF + VS) vsE = int'(VPOL);
            if (act) begin
`ifdef VGA_TESTPATTERN_EN
                k  = x / (HA / 8);
                rE = ((k >> 2) & 1) << (RW - 1);
                gE = ((k >> 1) & 1) << (GW - 1);
                bE = (k & 1) << (BW - 1);
`else
                k  = 0;
                rE = lastR;
                gE = lastG;
                bE = lastB;
`endif
            end
        end
        checkOutput("hcount",      int'(vif.hcount),      s % HT);
        checkOutput("vcount",      int'(vif.vcount),      (s / HT) % VT);
        checkOutput("frame_start", int'(vif.frame_start), int'(ce && !rst && (s % FT == 0)));
        checkOutput("line_start",  int'(vif.line_start),  int'(ce && !rst && (s % HT == 0)));
        checkOutput("frame_cnt",   int'(vif.frame_cnt),   ((s + FT - 1) / FT) % (1 << FCW));
        checkOutput("de",          int'(vif.de),          int'(act));
        checkOutput("hsync",       int'(vif.hsync),       hsE);
        checkOutput("vsync",       int'(vif.vsync),       vsE);
        checkOutput("rout",        int'(vif.rout),        rE);
        checkOutput("gout",        int'(vif.gout),        gE);
        checkOutput("bout",        int'(vif.bout),        bE);
    endtask

    task automatic runCycle(input bit ceV, input bit rstV);
        @(negedge clk);
        applyStimulus(ceV, rstV);
        #1;
        checkAll();
        @(posedge clk);
        if (rstV) begin
            s = 0;
        end else if (ceV) begin
            lastR = int'(vif.rin);
            lastG = int'(vif.gin);
            lastB = int'(vif.bin);
            s++;
        end
    endtask

    initial begin
        int  budget;
        bit  hit;
        applyStimulus(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        s = 0;

        // Continuous pixels: long enough for the frame counter to wrap.
        for (int i = 0; i < 17 * FT + 50; i++) runCycle(1'b1, 1'b0);

        // Half-rate pixel enable.
        for (int i = 0; i < 2 * FT + 40; i++) runCycle(i % 2 == 0, 1'b0);

        // Reset in the horizontal blanking of an active line.
        budget = 0;
        hit    = 1'b0;
        while (!hit && budget < 2 * FT) begin
            if ((s % HT == 20) && ((s / HT) % VT == 6)) hit = 1'b1;
            else runCycle(1'b1, 1'b0);
            budget++;
        end
        checkOutput("reach_reset_point", int'(hit), 1);
        runCycle(1'b1, 1'b1);
        for (int i = 0; i < LAT + 4; i++) runCycle(1'b1, 1'b0);

        // Random enable with sparse random resets.
        for (int i = 0; i < 3000; i++)
            runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
